ppm_freq_lock_ctrl: RTL and testbench
=====================================

Name: ppm_freq_lock_ctrl

Overview:
Sequencing controller for the 16-PPM frequency recovery block.
- Holds frequency recovery in reset, releases it, programs its pulse threshold, and watches its pulse_detected, interpulse_cycles and intrasymbol_pulses outputs.
- Declares frequency lock (drives freq_ok) after a run of consistent pulse measurements.
- Detects loss of lock and re-acquires automatically.
- Sits between the receiver top-level control (start/abort) and the frequency recovery instance.

Parameters:
SYMBOL_CHIPS, 16, chips per PPM symbol; sets interpulse_cycles width to ceilLog2(SYMBOL_CHIPS)+1.
CHIP_BITS, 1, width of the SPAD count and pulse threshold.
RESET_CYCLES, 2, cycles fr_resetn is held low in RST (>=1).
LOCK_COUNT, 8, consecutive good events required for lock (>=1).
UNLOCK_MISSES, 4, consecutive bad events in LOCKED that cause loss of lock (>=1).
TIMEOUT_CYCLES, 4096, maximum ACQ duration before failure.
STALL_CYCLES, 64, cycles without an event in LOCKED that count as one bad event.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin acquisition; accepted in IDLE or FAIL only
abort  in  1  return to IDLE from any state; wins over start
cfg_pulse_threshold  in  CHIP_BITS  threshold, latched on accepted start
pulse_detected  in  1  from frequency recovery; a rising edge is one event
interpulse_cycles  in  ceilLog2(SYMBOL_CHIPS)+1  from frequency recovery
intrasymbol_pulses  in  2  from frequency recovery
fr_resetn  out  1  reset to frequency recovery (active low)
pulse_threshold  out  CHIP_BITS  threshold to frequency recovery
freq_ok  out  1  lock indication to frequency recovery and downstream
busy  out  1  high in RST, ACQ, LOCKED
locked  out  1  high in LOCKED
lock_fail  out  1  high in FAIL
lock_lost  out  1  one-cycle pulse on loss of lock

Behaviour:
- Reset is asynchronous, active-low resetn. Reset values: state=IDLE; fr_resetn=0, pulse_threshold=0, freq_ok=0, busy=0, locked=0, lock_fail=0, lock_lost=0; all counters 0.
- All outputs are registered and decoded from the registered state.
- Event detection:
  - evt = pulse_detected & ~pulse_detected_q, with pulse_detected_q registered.
  - interpulse_cycles and intrasymbol_pulses are sampled in the evt cycle.
  - bad event: interpulse_cycles==0, OR interpulse_cycles==all-ones (saturated), OR intrasymbol_pulses>=2. Otherwise the event is good.
  - Events are ignored in IDLE, RST and FAIL.
- IDLE: fr_resetn=0. On start: latch cfg_pulse_threshold, go to RST.
- RST: fr_resetn=0 for exactly RESET_CYCLES cycles, then go to ACQ. Entering ACQ clears good_cnt, miss_cnt, tmo_cnt and stall_cnt.
- ACQ: fr_resetn=1, freq_ok=0, tmo_cnt increments every cycle.
  - Good event: good_cnt+1. When good_cnt reaches LOCK_COUNT, go to LOCKED.
  - Bad event: good_cnt=0.
  - tmo_cnt reaching TIMEOUT_CYCLES-1 goes to FAIL.
  - Lock and timeout in the same cycle: lock wins.
- LOCKED: freq_ok=1, locked=1.
  - Good event: miss_cnt=0, stall_cnt=0.
  - Bad event: miss_cnt+1, stall_cnt=0.
  - stall_cnt reaching STALL_CYCLES-1 with no event: counts as one bad event and clears stall_cnt.
  - When miss_cnt reaches UNLOCK_MISSES: pulse lock_lost for 1 cycle, clear freq_ok, go to RST. The latched threshold is kept.
- FAIL: lock_fail=1, fr_resetn=0.
  - start: re-latch threshold, go to RST.
  - abort: go to IDLE.
- abort in any state: go to IDLE next cycle; freq_ok and locked drop that cycle; lock_lost is not pulsed.
- start in RST, ACQ or LOCKED is ignored.
- Latency for start accepted at cycle 0:
  - state=RST at cycle 1.
  - fr_resetn low for cycles 1..RESET_CYCLES, high from cycle RESET_CYCLES+1.
  - freq_ok rises 1 cycle after the LOCK_COUNT-th good event.
- Counter widths: sized with ceilLog2 of their parameter; counters never wrap because they are bounded by their terminal compare.

Optional Feature:
PPM_LOCK_STATS_EN:
- Defined: adds outputs stat_good[15:0], stat_bad[15:0] and stat_relocks[7:0].
  - Counts are taken in ACQ and LOCKED; each counter saturates.
  - A stall counts toward stat_bad.
  - All three clear on resetn and on an accepted start from IDLE/FAIL, but not on automatic re-acquire.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Clean lock: start, then 8 events with interpulse_cycles=16, intrasymbol_pulses=1 -> fr_resetn low exactly 2 cycles; freq_ok=1 and locked=1 one cycle after the 8th event.
- Broken run: 5 good events, 1 with intrasymbol_pulses=2, then 8 good -> lock only after the final 8th good event (13 good events total).
- Timeout: TIMEOUT_CYCLES=256, only bad events (interpulse_cycles=31) -> lock_fail=1 at cycle 256 of ACQ; start re-enters RST with the new threshold.
- Loss of lock: after lock, 3 bad, 1 good, 4 bad -> no loss after the first 3; after the final 4th bad, lock_lost pulses 1 cycle, freq_ok=0, state RST, then ACQ.
- Stall: after lock, no pulses for 4*64 cycles -> lock_lost at cycle 256.
- abort mid-ACQ and mid-LOCKED -> IDLE next cycle, fr_resetn=0, lock_lost=0. resetn asserted mid-LOCKED -> all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/ppm_freq_lock_ctrl_if.sv
// ppm_freq_lock_ctrl_if: control, status and frequency-recovery signals of ppm_freq_lock_ctrl.
// Optional macro PPM_LOCK_STATS_EN adds the statistics outputs.
`default_nettype none

interface ppm_freq_lock_ctrl_if #(
  parameter int SYMBOL_CHIPS = 16,
  parameter int CHIP_BITS    = 1
);
  localparam int IP_W = $clog2(SYMBOL_CHIPS) + 1;

  logic                 start;
  logic                 abort;
  logic [CHIP_BITS-1:0] cfg_pulse_threshold;
  logic                 pulse_detected;
  logic [IP_W-1:0]      interpulse_cycles;
  logic [1:0]           intrasymbol_pulses;
  logic                 fr_resetn;
  logic [CHIP_BITS-1:0] pulse_threshold;
  logic                 freq_ok;
  logic                 busy;
  logic                 locked;
  logic                 lock_fail;
  logic                 lock_lost;
`ifdef PPM_LOCK_STATS_EN
  logic [15:0]          stat_good;
  logic [15:0]          stat_bad;
  logic [7:0]           stat_relocks;

  modport slave (
    input  start, abort, cfg_pulse_threshold,
    input  pulse_detected, interpulse_cycles, intrasymbol_pulses,
    output fr_resetn, pulse_threshold, freq_ok,
    output busy, locked, lock_fail, lock_lost,
    output stat_good, stat_bad, stat_relocks
  );

  modport master (
    output start, abort, cfg_pulse_threshold,
    output pulse_detected, interpulse_cycles, intrasymbol_pulses,
    input  fr_resetn, pulse_threshold, freq_ok,
    input  busy, locked, lock_fail, lock_lost,
    input  stat_good, stat_bad, stat_relocks
  );
`else
  modport slave (
    input  start, abort, cfg_pulse_threshold,
    input  pulse_detected, interpulse_cycles, intrasymbol_pulses,
    output fr_resetn, pulse_threshold, freq_ok,
    output busy, locked, lock_fail, lock_lost
  );

  modport master (
    output start, abort, cfg_pulse_threshold,
    output pulse_detected, interpulse_cycles, intrasymbol_pulses,
    input  fr_resetn, pulse_threshold, freq_ok,
    input  busy, locked, lock_fail, lock_lost
  );
`endif

endinterface

`default_nettype wire

// File: rtl/ppm_freq_lock_ctrl.sv
// ppm_freq_lock_ctrl: sequences 16-PPM frequency recovery through reset, acquisition and lock.
// Optional macro PPM_LOCK_STATS_EN adds saturating good/bad/relock statistics counters.
`default_nettype none

module ppm_freq_lock_ctrl #(
  parameter int SYMBOL_CHIPS   = 16,
  parameter int CHIP_BITS      = 1,
  parameter int RESET_CYCLES   = 2,
  parameter int LOCK_COUNT     = 8,
  parameter int UNLOCK_MISSES  = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STALL_CYCLES   = 64
) (
  input wire clk,
  input wire resetn,
  ppm_freq_lock_ctrl_if.slave bus
);

  localparam int IP_W    = $clog2(SYMBOL_CHIPS) + 1;
  localparam int RST_W   = (RESET_CYCLES   > 1) ? $clog2(RESET_CYCLES)   : 1;
  localparam int GOOD_W  = (LOCK_COUNT     > 1) ? $clog2(LOCK_COUNT)     : 1;
  localparam int MISS_W  = (UNLOCK_MISSES  > 1) ? $clog2(UNLOCK_MISSES)  : 1;
  localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int STALL_W = (STALL_CYCLES   > 1) ? $clog2(STALL_CYCLES)   : 1;

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RESET_CYCLES - 1);
  localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_MISSES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_ACQ    = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CHIP_BITS-1:0] thr_q, thr_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                 pulse_q;
  logic                 lost_d;
  logic                 miss_hit;

  logic                 fr_resetn_q, freq_ok_q, busy_q, locked_q, lock_fail_q, lock_lost_q;

  logic                 evt;
  logic                 evt_bad;
  logic [IP_W-1:0]      ip;

  assign ip      = bus.interpulse_cycles;
  assign evt     = bus.pulse_detected & ~pulse_q;
  // Zero or saturated spacing, or multiple pulses inside one symbol, is not a usable measurement.
  assign evt_bad = (ip == '0) | (&ip) | bus.intrasymbol_pulses[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      thr_q       <= '0;
      rst_cnt_q   <= '0;
      good_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      stall_cnt_q <= '0;
      pulse_q     <= 1'b0;
      fr_resetn_q <= 1'b0;
      freq_ok_q   <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      lock_fail_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      rst_cnt_q   <= rst_cnt_d;
      good_cnt_q  <= good_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      pulse_q     <= bus.pulse_detected;
      fr_resetn_q <= (state_d == S_ACQ) || (state_d == S_LOCKED);
      freq_ok_q   <= (state_d == S_LOCKED);
      busy_q      <= (state_d == S_RST) || (state_d == S_ACQ) || (state_d == S_LOCKED);
      locked_q    <= (state_d == S_LOCKED);
      lock_fail_q <= (state_d == S_FAIL);
      lock_lost_q <= lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    rst_cnt_d   = rst_cnt_q;
    good_cnt_d  = good_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    stall_cnt_d = stall_cnt_q;
    lost_d      = 1'b0;
    miss_hit    = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_FAIL: begin
          if (bus.start) begin
            thr_d     = bus.cfg_pulse_threshold;
            rst_cnt_d = '0;
            state_d   = S_RST;
          end
        end
        S_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            good_cnt_d  = '0;
            miss_cnt_d  = '0;
            tmo_cnt_d   = '0;
            stall_cnt_d = '0;
            state_d     = S_ACQ;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        S_ACQ: begin
          if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
          if (evt && evt_bad) begin
            good_cnt_d = '0;
          end else if (evt) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d = S_LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end
          // Lock takes priority over a coincident timeout.
          if (state_d != S_LOCKED && tmo_cnt_q == TMO_LAST) begin
            state_d = S_FAIL;
          end
        end
        S_LOCKED: begin
          if (evt) begin
            stall_cnt_d = '0;
            if (evt_bad) begin
              miss_hit = 1'b1;
            end else begin
              miss_cnt_d = '0;
            end
          end else if (stall_cnt_q == STALL_LAST) begin
            stall_cnt_d = '0;
            miss_hit    = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
          if (miss_hit) begin
            if (miss_cnt_q == MISS_LAST) begin
              rst_cnt_d = '0;
              lost_d    = 1'b1;
              state_d   = S_RST;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.fr_resetn       = fr_resetn_q;
  assign bus.pulse_threshold = thr_q;
  assign bus.freq_ok         = freq_ok_q;
  assign bus.busy            = busy_q;
  assign bus.locked          = locked_q;
  assign bus.lock_fail       = lock_fail_q;
  assign bus.lock_lost       = lock_lost_q;

`ifdef PPM_LOCK_STATS_EN
  logic [15:0] stat_good_q;
  logic [15:0] stat_bad_q;
  logic [7:0]  stat_relocks_q;
  logic        st_active;
  logic        st_clear;
  logic        st_good;
  logic        st_bad;
  logic        st_stall;

  assign st_active = (state_q == S_ACQ) || (state_q == S_LOCKED);
  assign st_clear  = bus.start && !bus.abort && ((state_q == S_IDLE) || (state_q == S_FAIL));
  assign st_stall  = (state_q == S_LOCKED) && !evt && (stall_cnt_q == STALL_LAST);
  assign st_good   = st_active && evt && !evt_bad;
  assign st_bad    = (st_active && evt && evt_bad) || st_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_good_q    <= '0;
      stat_bad_q     <= '0;
      stat_relocks_q <= '0;
    end else if (st_clear) begin
      stat_good_q    <= '0;
      stat_bad_q     <= '0;
      stat_relocks_q <= '0;
    end else begin
      if (st_good && stat_good_q != '1) begin
        stat_good_q <= stat_good_q + 1'b1;
      end
      if (st_bad && stat_bad_q != '1) begin
        stat_bad_q <= stat_bad_q + 1'b1;
      end
      if (lost_d && stat_relocks_q != '1) begin
        stat_relocks_q <= stat_relocks_q + 1'b1;
      end
    end
  end

  assign bus.stat_good    = stat_good_q;
  assign bus.stat_bad     = stat_bad_q;
  assign bus.stat_relocks = stat_relocks_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ppm_freq_lock_ctrl.sv
// tb_ppm_freq_lock_ctrl: directed checks of ppm_freq_lock_ctrl sequencing, lock, loss, timeout and abort.
`default_nettype none

module tb_ppm_freq_lock_ctrl;

  localparam int CB = 4;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  ppm_freq_lock_ctrl_if #(.SYMBOL_CHIPS(16), .CHIP_BITS(CB)) bus ();

  ppm_freq_lock_ctrl #(
    .SYMBOL_CHIPS  (16),
    .CHIP_BITS     (CB),
    .RESET_CYCLES  (2),
    .LOCK_COUNT    (8),
    .UNLOCK_MISSES (4),
    .TIMEOUT_CYCLES(256),
    .STALL_CYCLES  (64)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status vector {fr_resetn, freq_ok, busy, locked, lock_fail, lock_lost}
  localparam logic [5:0] ST_IDLE = 6'b000000;
  localparam logic [5:0] ST_RST  = 6'b001000;
  localparam logic [5:0] ST_LOST = 6'b001001;
  localparam logic [5:0] ST_ACQ  = 6'b101000;
  localparam logic [5:0] ST_LOCK = 6'b111100;
  localparam logic [5:0] ST_FAIL = 6'b000010;

  logic [5:0] st;
  assign st = {bus.fr_resetn, bus.freq_ok, bus.busy, bus.locked, bus.lock_fail, bus.lock_lost};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event cycle, then returns one cycle later with pulse_detected low.
  task automatic event_pulse(input logic [4:0] ipc, input logic [1:0] isp);
    bus.pulse_detected     = 1'b1;
    bus.interpulse_cycles  = ipc;
    bus.intrasymbol_pulses = isp;
    tick();
    bus.pulse_detected = 1'b0;
  endtask

  task automatic start_acq(input logic [CB-1:0] thr);
    bus.start               = 1'b1;
    bus.cfg_pulse_threshold = thr;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_pulse_threshold = '0;
    bus.pulse_detected = 1'b0;
    bus.interpulse_cycles = '0;
    bus.intrasymbol_pulses = '0;
    tick();
    tick();
    chk("reset_status", 16'(st), 16'(ST_IDLE));
    chk("reset_thr", 16'(bus.pulse_threshold), 16'h0);
    resetn = 1'b1;
    tick();
    chk("idle_status", 16'(st), 16'(ST_IDLE));

    // Clean lock
    bus.start = 1'b1;
    bus.cfg_pulse_threshold = 4'hA;
    tick();
    bus.start = 1'b0;
    chk("rst_cycle1", 16'(st), 16'(ST_RST));
    tick();
    chk("rst_cycle2", 16'(st), 16'(ST_RST));
    tick();
    chk("acq_entry", 16'(st), 16'(ST_ACQ));
    chk("thr_latched", 16'(bus.pulse_threshold), 16'hA);
    for (int i = 0; i < 7; i++) begin
      event_pulse(5'd16, 2'd1);
      tick();
    end
    chk("acq_after7", 16'(st), 16'(ST_ACQ));
    event_pulse(5'd16, 2'd1);
    chk("lock_after8", 16'(st), 16'(ST_LOCK));
    tick();

    // Loss of lock: 3 bad, 1 good, 4 bad
    for (int i = 0; i < 3; i++) begin
      event_pulse(5'd31, 2'd1);
      tick();
    end
    chk("locked_after3bad", 16'(st), 16'(ST_LOCK));
    event_pulse(5'd16, 2'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      event_pulse(5'd31, 2'd1);
      tick();
    end
    chk("locked_after_good3bad", 16'(st), 16'(ST_LOCK));
    event_pulse(5'd31, 2'd1);
    chk("loss_pulse", 16'(st), 16'(ST_LOST));
    tick();
    chk("loss_rst2", 16'(st), 16'(ST_RST));
    tick();
    chk("loss_reacq", 16'(st), 16'(ST_ACQ));
    chk("thr_kept", 16'(bus.pulse_threshold), 16'hA);

    // Broken run: 5 good, one with intrasymbol_pulses=2, then 8 good
    for (int i = 0; i < 5; i++) begin
      event_pulse(5'd16, 2'd1);
      tick();
    end
    event_pulse(5'd16, 2'd2);
    tick();
    for (int i = 0; i < 7; i++) begin
      event_pulse(5'd16, 2'd1);
      tick();
    end
    chk("broken_not_locked", 16'(st), 16'(ST_ACQ));
    event_pulse(5'd16, 2'd1);
    chk("broken_lock", 16'(st), 16'(ST_LOCK));

    // Stall: no events for 4*64 cycles
    for (int i = 0; i < 255; i++) tick();
    chk("stall_255", 16'(st), 16'(ST_LOCK));
    tick();
    chk("stall_256_lost", 16'(st), 16'(ST_LOST));
    tick();
    tick();
    chk("stall_reacq", 16'(st), 16'(ST_ACQ));

    // Timeout with only saturated interpulse counts
    for (int i = 0; i < 127; i++) begin
      event_pulse(5'd31, 2'd1);
      tick();
    end
    chk("tmo_254", 16'(st), 16'(ST_ACQ));
    tick();
    chk("tmo_255", 16'(st), 16'(ST_ACQ));
    tick();
    chk("tmo_fail", 16'(st), 16'(ST_FAIL));
    tick();
    chk("fail_hold", 16'(st), 16'(ST_FAIL));
    bus.start = 1'b1;
    bus.cfg_pulse_threshold = 4'h5;
    tick();
    bus.start = 1'b0;
    chk("fail_restart", 16'(st), 16'(ST_RST));
    chk("fail_new_thr", 16'(bus.pulse_threshold), 16'h5);
    tick();
    tick();
    chk("fail_reacq", 16'(st), 16'(ST_ACQ));

    // Abort mid-ACQ, then start+abort together in IDLE
    for (int i = 0; i < 3; i++) begin
      event_pulse(5'd16, 2'd1);
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_acq", 16'(st), 16'(ST_IDLE));
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.cfg_pulse_threshold = 4'hC;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_wins", 16'(st), 16'(ST_IDLE));
    chk("abort_wins_thr", 16'(bus.pulse_threshold), 16'h5);

    // Abort mid-LOCKED; start while locked is ignored
    start_acq(4'h3);
    for (int i = 0; i < 8; i++) begin
      event_pulse(5'd16, 2'd1);
      tick();
    end
    chk("relock", 16'(st), 16'(ST_LOCK));
    bus.start = 1'b1;
    bus.cfg_pulse_threshold = 4'hF;
    tick();
    bus.start = 1'b0;
    chk("start_ignored", 16'(st), 16'(ST_LOCK));
    chk("start_ignored_thr", 16'(bus.pulse_threshold), 16'h3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_locked", 16'(st), 16'(ST_IDLE));

    // Zero interpulse count breaks the run; then asynchronous reset while locked
    start_acq(4'h6);
    for (int i = 0; i < 7; i++) begin
      event_pulse(5'd16, 2'd1);
      tick();
    end
    event_pulse(5'd0, 2'd0);
    tick();
    chk("zero_ip_bad", 16'(st), 16'(ST_ACQ));
    for (int i = 0; i < 8; i++) begin
      event_pulse(5'd16, 2'd1);
      tick();
    end
    chk("lock_before_rst", 16'(st), 16'(ST_LOCK));
    chk("thr_before_rst", 16'(bus.pulse_threshold), 16'h6);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_status", 16'(st), 16'(ST_IDLE));
    chk("async_rst_thr", 16'(bus.pulse_threshold), 16'h0);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_idle", 16'(st), 16'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
